scsi_strobe_timer: RTL and testbench

- Peripheral-port strobe timing stage, directly downstream of the SCSI state machine.
- Takes the SCSI state machine's level requests (read/write, register-select or DMA-acknowledge) and generates the timed _CSS, _DACK, _IOR, _IOW and PDATA_OE_ waveforms for the WD33C93A.
- Enforces address setup, strobe width, hold and recovery times, and returns a DONE handshake and a read-data LATCH strobe.
- Replaces the direct combinational strobe assignments at the top level.

---
 rtl/scsi_strobe_timer.sv | 236 +++++++++++++++++++++++
 tb/tb_scsi_strobe_timer.sv | 358 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/scsi_strobe_timer.sv
// -----------------------------------------------------------------------------
// scsi_strobe_timer
//
// Peripheral-port strobe timing stage that sits directly after the SCSI state
// machine. It takes level requests and turns them into timed WD33C93A bus
// cycles. A request is read or write, aimed at either register-select or
// DMA-acknowledge. Each bus cycle has the following phases:
//   SETUP   : select (_CSS or _DACK) and PDATA_OE_ low, strobes high
//   STROBE  : _IOR or _IOW low; a read raises LATCH in the last cycle
//   HOLD    : strobe high, select and PDATA_OE_ still low; DONE in last cycle
//   RECOVER : every bus signal idle, BUSY still high
// Every output is a flop, so no input reaches an output combinationally.
//
// Ports
//   nCLK       clock, all state on its rising edge
//   RESET_     asynchronous active-low reset
//   RD_REQ     read request level
//   WR_REQ     write request level
//   CS_REQ     target is a WD33C93A register (_CSS)
//   DACK_REQ   target is a DMA data transfer (_DACK)
//   PRESET     peripheral reset, overrides everything
//   _IOR       active-low read strobe
//   _IOW       active-low write strobe
//   _CSS       active-low chip select
//   _DACK      active-low DMA acknowledge
//   PDATA_OE_  active-low peripheral-bus level-shifter enable
//   LATCH      one-cycle pulse to capture read data
//   DONE       one-cycle completion pulse
//   BUSY       high whenever the block is not idle
//   ERR        one-cycle pulse when an illegal request is rejected
// -----------------------------------------------------------------------------
module scsi_strobe_timer #(
  parameter int unsigned SETUP_CYC    = 1,  // 1..15
  parameter int unsigned PULSE_CYC    = 3,  // 1..15
  parameter int unsigned HOLD_CYC     = 1,  // 1..15
  parameter int unsigned RECOVERY_CYC = 2   // 1..15
) (
  input  logic nCLK,
  input  logic RESET_,
  input  logic RD_REQ,
  input  logic WR_REQ,
  input  logic CS_REQ,
  input  logic DACK_REQ,
  input  logic PRESET,
  output logic _IOR,
  output logic _IOW,
  output logic _CSS,
  output logic _DACK,
  output logic PDATA_OE_,
  output logic LATCH,
  output logic DONE,
  output logic BUSY,
  output logic ERR
);

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    STROBE,
    HOLD,
    RECOVER
  } state_t;

  // The counter is loaded with (phase length - 1) on entry to each phase.
  localparam logic [3:0] SETUP_LD = 4'(SETUP_CYC - 1);
  localparam logic [3:0] PULSE_LD = 4'(PULSE_CYC - 1);
  localparam logic [3:0] HOLD_LD  = 4'(HOLD_CYC - 1);
  localparam logic [3:0] REC_LD   = 4'(RECOVERY_CYC - 1);

  state_t     state, state_nx;
  logic [3:0] cnt, cnt_nx;
  logic       armed, armed_nx;
  logic       dir_rd, dir_rd_nx;   // latched direction: 1 = read
  logic       tgt_cs, tgt_cs_nx;   // latched target: 1 = _CSS, 0 = _DACK

  logic       any_req, legal_req, decide, accept, reject;

  logic ior_nx, iow_nx, css_nx, dack_nx, oe_nx;
  logic latch_nx, done_nx, busy_nx, err_nx;

  // ---------------------------------------------------------------------------
  // Next-state, counter and registered-output decode
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal written here is given a default first, so no path
    // leaves a value unassigned and no latch can be inferred.
    state_nx  = state;
    cnt_nx    = (cnt != 4'd0) ? cnt - 4'd1 : 4'd0;  // saturate, never wrap
    dir_rd_nx = dir_rd;
    tgt_cs_nx = tgt_cs;
    armed_nx  = armed;

    any_req   = RD_REQ | WR_REQ;
    legal_req = (RD_REQ ^ WR_REQ) & (CS_REQ ^ DACK_REQ);
    // Only one decision is made per armed idle period. After that, the
    // requester must drop both RD_REQ and WR_REQ before the next decision.
    decide    = (state == IDLE) && !PRESET && armed && any_req;
    accept    = decide && legal_req;
    reject    = decide && !legal_req;

    if (!any_req) begin
      armed_nx = 1'b1;
    end else if (decide) begin
      armed_nx = 1'b0;
    end

    if (PRESET) begin
      // While PRESET is high the counter stays at the recovery reload value.
      // The countdown starts only after PRESET falls.
      state_nx = RECOVER;
      cnt_nx   = REC_LD;
    end else begin
      unique case (state)
        IDLE: begin
          cnt_nx = 4'd0;
          if (accept) begin
            state_nx  = SETUP;
            cnt_nx    = SETUP_LD;
            dir_rd_nx = RD_REQ;
            tgt_cs_nx = CS_REQ;
          end
        end
        SETUP: begin
          if (cnt == 4'd0) begin
            state_nx = STROBE;
            cnt_nx   = PULSE_LD;
          end
        end
        STROBE: begin
          if (cnt == 4'd0) begin
            state_nx = HOLD;
            cnt_nx   = HOLD_LD;
          end
        end
        HOLD: begin
          if (cnt == 4'd0) begin
            state_nx = RECOVER;
            cnt_nx   = REC_LD;
          end
        end
        RECOVER: begin
          if (cnt == 4'd0) begin
            state_nx = IDLE;
            cnt_nx   = 4'd0;
          end
        end
        default: begin
          state_nx = IDLE;
          cnt_nx   = 4'd0;
        end
      endcase
    end

    // The outputs are decoded from the next state, so each flop shows the
    // phase that the block is entering on this edge.
    ior_nx   = 1'b1;
    iow_nx   = 1'b1;
    css_nx   = 1'b1;
    dack_nx  = 1'b1;
    oe_nx    = 1'b1;
    latch_nx = 1'b0;
    done_nx  = 1'b0;
    busy_nx  = (state_nx != IDLE);
    err_nx   = reject;

    if (PRESET) begin
      // The peripheral reset is signalled by driving both strobes low with
      // the selects idle.
      ior_nx = 1'b0;
      iow_nx = 1'b0;
    end else begin
      unique case (state_nx)
        SETUP: begin
          css_nx  = !tgt_cs_nx;
          dack_nx = tgt_cs_nx;
          oe_nx   = 1'b0;
        end
        STROBE: begin
          css_nx   = !tgt_cs_nx;
          dack_nx  = tgt_cs_nx;
          oe_nx    = 1'b0;
          ior_nx   = !dir_rd_nx;
          iow_nx   = dir_rd_nx;
          latch_nx = dir_rd_nx && (cnt_nx == 4'd0);
        end
        HOLD: begin
          css_nx  = !tgt_cs_nx;
          dack_nx = tgt_cs_nx;
          oe_nx   = 1'b0;
          done_nx = (cnt_nx == 4'd0);
        end
        default: ;  // IDLE and RECOVER leave the bus idle
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // State and output registers
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments only. All flops then
  // update together from values sampled before the edge.
  always_ff @(posedge nCLK or negedge RESET_) begin
    if (!RESET_) begin
      state     <= IDLE;
      cnt       <= 4'd0;
      armed     <= 1'b1;
      dir_rd    <= 1'b0;
      tgt_cs    <= 1'b0;
      _IOR      <= 1'b1;
      _IOW      <= 1'b1;
      _CSS      <= 1'b1;
      _DACK     <= 1'b1;
      PDATA_OE_ <= 1'b1;
      LATCH     <= 1'b0;
      DONE      <= 1'b0;
      BUSY      <= 1'b0;
      ERR       <= 1'b0;
    end else begin
      state     <= state_nx;
      cnt       <= cnt_nx;
      armed     <= armed_nx;
      dir_rd    <= dir_rd_nx;
      tgt_cs    <= tgt_cs_nx;
      _IOR      <= ior_nx;
      _IOW      <= iow_nx;
      _CSS      <= css_nx;
      _DACK     <= dack_nx;
      PDATA_OE_ <= oe_nx;
      LATCH     <= latch_nx;
      DONE      <= done_nx;
      BUSY      <= busy_nx;
      ERR       <= err_nx;
    end
  end

endmodule

// File: tb/tb_scsi_strobe_timer.sv
// -----------------------------------------------------------------------------
// tb_scsi_strobe_timer
//
// Testbench for scsi_strobe_timer. It uses two instances: dut_a has the
// default timing (1/3/1/2) and dut_b has 2/5/2/1. Both instances see the same
// inputs. A timeline model predicts every output of each instance in every
// cycle. The model tracks an access by its absolute start cycle and derives
// the phases from the cycle offset.
// -----------------------------------------------------------------------------
module tb_scsi_strobe_timer;

  typedef struct packed {
    logic ior, iow, css, dack, oe, latch, done, busy, err;
  } outs_t;

  typedef struct {
    int s, p, h, r;
    int start, end_cyc, pre_cyc, err_cyc;
    bit acc_valid, acc_rd, acc_cs, armed;
  } model_t;

  typedef struct {
    bit    rd, wr, cs, dk, pre;
    outs_t exp;
  } vec_t;

  localparam outs_t O_IDLE = 9'b111110000;

  logic nCLK   = 1'b0;
  logic RESET_ = 1'b0;
  logic rd = 1'b0, wr = 1'b0, cs = 1'b0, dk = 1'b0, pre = 1'b0;

  logic a_ior, a_iow, a_css, a_dack, a_oe, a_latch, a_done, a_busy, a_err;
  logic b_ior, b_iow, b_css, b_dack, b_oe, b_latch, b_done, b_busy, b_err;
  outs_t a_out, b_out;
  assign a_out = {a_ior, a_iow, a_css, a_dack, a_oe, a_latch, a_done, a_busy, a_err};
  assign b_out = {b_ior, b_iow, b_css, b_dack, b_oe, b_latch, b_done, b_busy, b_err};

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;
  int cyc      = 0;
  model_t m [2];

  always #5 nCLK = ~nCLK;

  scsi_strobe_timer dut_a (
    .nCLK(nCLK), .RESET_(RESET_),
    .RD_REQ(rd), .WR_REQ(wr), .CS_REQ(cs), .DACK_REQ(dk), .PRESET(pre),
    ._IOR(a_ior), ._IOW(a_iow), ._CSS(a_css), ._DACK(a_dack),
    .PDATA_OE_(a_oe), .LATCH(a_latch), .DONE(a_done), .BUSY(a_busy), .ERR(a_err)
  );

  scsi_strobe_timer #(
    .SETUP_CYC(2), .PULSE_CYC(5), .HOLD_CYC(2), .RECOVERY_CYC(1)
  ) dut_b (
    .nCLK(nCLK), .RESET_(RESET_),
    .RD_REQ(rd), .WR_REQ(wr), .CS_REQ(cs), .DACK_REQ(dk), .PRESET(pre),
    ._IOR(b_ior), ._IOW(b_iow), ._CSS(b_css), ._DACK(b_dack),
    .PDATA_OE_(b_oe), .LATCH(b_latch), .DONE(b_done), .BUSY(b_busy), .ERR(b_err)
  );

  // ---------------------------------------------------------------------------
  // Reference model
  // ---------------------------------------------------------------------------
  function automatic model_t reset_model(int s, int p, int h, int r);
    model_t md;
    md.s = s; md.p = p; md.h = h; md.r = r;
    md.start = -100; md.end_cyc = -100; md.pre_cyc = -100; md.err_cyc = -100;
    md.acc_valid = 1'b0; md.acc_rd = 1'b0; md.acc_cs = 1'b0; md.armed = 1'b1;
    return md;
  endfunction

  // Apply the inputs sampled at edge n. Cycle n is the interval after edge n.
  function automatic model_t step(model_t md, int n, bit i_rd, bit i_wr,
                                  bit i_cs, bit i_dk, bit i_pre);
    bit idle = (n - 1 > md.end_cyc);
    bit ok   = (i_rd ^ i_wr) && (i_cs ^ i_dk);
    bit took = 1'b0;
    if (i_pre) begin
      md.acc_valid = 1'b0;
      md.pre_cyc   = n;
      md.end_cyc   = n + md.r - 1;
    end else if (idle && md.armed && (i_rd || i_wr)) begin
      took = 1'b1;
      if (ok) begin
        md.acc_valid = 1'b1;
        md.start     = n;
        md.acc_rd    = i_rd;
        md.acc_cs    = i_cs;
        md.end_cyc   = n + md.s + md.p + md.h + md.r - 1;
      end else begin
        md.err_cyc = n;
      end
    end
    if (!i_rd && !i_wr) md.armed = 1'b1;
    else if (took)      md.armed = 1'b0;
    return md;
  endfunction

  function automatic outs_t predict(model_t md, int n);
    outs_t o = O_IDLE;
    o.busy = (n <= md.end_cyc);
    o.err  = (n == md.err_cyc);
    if (n == md.pre_cyc) begin
      o.ior = 1'b0;
      o.iow = 1'b0;
    end else if (md.acc_valid && n <= md.end_cyc) begin
      int off = n - md.start + 1;
      int a   = md.s;
      int b   = md.s + md.p;
      int c   = md.s + md.p + md.h;
      if (off <= c) begin
        if (md.acc_cs) o.css = 1'b0; else o.dack = 1'b0;
        o.oe = 1'b0;
        if (off > a && off <= b) begin
          if (md.acc_rd) o.ior = 1'b0; else o.iow = 1'b0;
        end
        if (off == b && md.acc_rd) o.latch = 1'b1;
        if (off == c)              o.done  = 1'b1;
      end
    end
    return o;
  endfunction

  always @(posedge nCLK or negedge RESET_) begin
    if (!RESET_) begin
      m[0] <= reset_model(1, 3, 1, 2);
      m[1] <= reset_model(2, 5, 2, 1);
    end else begin
      cyc  <= cyc + 1;
      m[0] <= step(m[0], cyc + 1, rd, wr, cs, dk, pre);
      m[1] <= step(m[1], cyc + 1, rd, wr, cs, dk, pre);
    end
  end

  // ---------------------------------------------------------------------------
  // Helpers
  // ---------------------------------------------------------------------------
  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
    end
  endtask

  // Advance to the next falling edge and compare both instances to the model.
  task automatic tick();
    @(negedge nCLK);
    if (chk_en) begin
      check("model_a", 16'(a_out), 16'(predict(m[0], cyc)));
      check("model_b", 16'(b_out), 16'(predict(m[1], cyc)));
    end
  endtask

  task automatic set_in(input bit i_rd, input bit i_wr, input bit i_cs,
                        input bit i_dk, input bit i_pre);
    rd = i_rd; wr = i_wr; cs = i_cs; dk = i_dk; pre = i_pre;
  endtask

  task automatic wait_idle();
    int k = 0;
    while ((a_busy || b_busy) && k < 40) begin
      tick();
      k++;
    end
    check("idle_timeout", 16'(a_busy | b_busy), 16'd0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    vec_t vt [11];
    int   n_dack, n_iow, n_latch, n_start, n_done, k;
    int   css_fall, ior_fall, ior_rise, css_rise, ior_low;
    logic prev_busy, prev_css, prev_ior;

    // Default read to a register with the request held. The outputs for each
    // row are those in the cycle after that row's inputs are sampled.
    vt[0]  = '{1, 0, 1, 0, 0, 9'b110100010};  // SETUP
    vt[1]  = '{1, 0, 1, 0, 0, 9'b010100010};  // STROBE
    vt[2]  = '{1, 0, 1, 0, 0, 9'b010100010};  // STROBE
    vt[3]  = '{1, 0, 1, 0, 0, 9'b010101010};  // STROBE, LATCH
    vt[4]  = '{1, 0, 1, 0, 0, 9'b110100110};  // HOLD, DONE
    vt[5]  = '{1, 0, 1, 0, 0, 9'b111110010};  // RECOVER
    vt[6]  = '{1, 0, 1, 0, 0, 9'b111110010};  // RECOVER
    vt[7]  = '{1, 0, 1, 0, 0, 9'b111110000};  // IDLE, held request ignored
    vt[8]  = '{1, 0, 1, 0, 0, 9'b111110000};  // IDLE
    vt[9]  = '{0, 0, 0, 0, 0, 9'b111110000};  // drop -> re-arm
    vt[10] = '{1, 0, 1, 0, 0, 9'b110100010};  // new access starts

    // Reset state
    set_in(0, 0, 0, 0, 0);
    repeat (3) @(negedge nCLK);
    check("reset_a", 16'(a_out), 16'(O_IDLE));
    check("reset_b", 16'(b_out), 16'(O_IDLE));
    RESET_ = 1'b1;
    chk_en = 1'b1;
    tick();
    tick();

    // Table-driven default read
    for (int i = 0; i < 11; i++) begin
      set_in(vt[i].rd, vt[i].wr, vt[i].cs, vt[i].dk, vt[i].pre);
      tick();
      check($sformatf("vec%0d", i), 16'(a_out), 16'(vt[i].exp));
    end
    set_in(0, 0, 0, 0, 0);
    wait_idle();
    tick();

    // DMA write held for 20 cycles: exactly one access
    n_dack = 0; n_iow = 0; n_latch = 0; n_start = 0;
    prev_busy = a_busy;
    set_in(0, 1, 0, 1, 0);
    for (int i = 0; i < 20; i++) begin
      tick();
      n_dack  += int'(!a_dack);
      n_iow   += int'(!a_iow);
      n_latch += int'(a_latch);
      n_start += int'(a_busy && !prev_busy);
      prev_busy = a_busy;
    end
    check("wr_dack_cycles", 16'(n_dack), 16'd5);
    check("wr_iow_cycles", 16'(n_iow), 16'd3);
    check("wr_no_latch", 16'(n_latch), 16'd0);
    check("wr_one_access", 16'(n_start), 16'd1);
    set_in(0, 0, 0, 1, 0);
    tick();
    set_in(0, 1, 0, 1, 0);
    tick();
    check("wr_restart_busy", 16'(a_busy), 16'd1);
    set_in(0, 0, 0, 0, 0);
    wait_idle();
    tick();

    // Illegal requests
    set_in(1, 1, 1, 0, 0);
    tick();
    check("err_rdwr", 16'(a_out), 16'(9'b111110001));
    tick();
    check("err_rdwr_once", 16'(a_err), 16'd0);
    set_in(0, 0, 0, 0, 0);
    tick();
    set_in(1, 0, 1, 1, 0);
    tick();
    check("err_csdack", 16'(a_out), 16'(9'b111110001));
    tick();
    check("err_csdack_once", 16'(a_err), 16'd0);
    set_in(0, 0, 0, 0, 0);
    tick();

    // PRESET during the STROBE phase of a read
    set_in(1, 0, 1, 0, 0);
    k = 0;
    do begin
      tick();
      k++;
    end while (a_ior && k < 10);
    check("pre_strobe_seen", 16'(a_ior), 16'd0);
    pre = 1'b1;
    tick();
    check("pre_first", 16'({a_ior, a_iow, a_css, a_done, a_latch}), 16'(5'b00100));
    repeat (3) tick();
    pre = 1'b0;
    tick();
    check("pre_rel_strobes", 16'({a_ior, a_iow, a_busy}), 16'(3'b111));
    tick();
    check("pre_rel_idle", 16'(a_busy), 16'd0);
    set_in(0, 0, 0, 0, 0);
    wait_idle();
    tick();

    // Non-default timing on dut_b
    css_fall = -1; ior_fall = -1; ior_rise = -1; css_rise = -1; ior_low = 0;
    prev_css = b_css;
    prev_ior = b_ior;
    set_in(1, 0, 1, 0, 0);
    for (int i = 0; i < 30; i++) begin
      tick();
      if (i == 3) set_in(0, 1, 0, 1, 0);  // changed request is ignored
      if (prev_css && !b_css && css_fall < 0) css_fall = i;
      if (prev_ior && !b_ior && ior_fall < 0) ior_fall = i;
      if (!prev_ior && b_ior && ior_rise < 0) ior_rise = i;
      if (!prev_css && b_css && css_rise < 0) css_rise = i;
      ior_low += int'(!b_ior);
      prev_css = b_css;
      prev_ior = b_ior;
    end
    check("b_ior_width", 16'(ior_low), 16'd5);
    check("b_setup_gap", 16'(ior_fall - css_fall), 16'd2);
    check("b_hold_gap", 16'(css_rise - ior_rise), 16'd2);
    set_in(0, 0, 0, 0, 0);
    wait_idle();
    tick();

    // Asynchronous reset in the HOLD phase
    set_in(0, 1, 0, 1, 0);
    k = 0;
    do begin
      tick();
      k++;
    end while (!a_done && k < 20);
    check("hold_reached", 16'(a_done), 16'd1);
    #2 RESET_ = 1'b0;
    #1;
    check("async_reset_a", 16'(a_out), 16'(O_IDLE));
    check("async_reset_b", 16'(b_out), 16'(O_IDLE));
    set_in(0, 0, 0, 0, 0);
    tick();
    RESET_ = 1'b1;
    n_done = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      n_done += int'(a_done | b_done);
    end
    check("no_done_after_reset", 16'(n_done), 16'd0);

    // Randomised run against the model
    for (int i = 0; i < 2500; ) begin
      int len;
      int kind;
      len  = $urandom_range(1, 12);
      kind = $urandom_range(0, 7);
      if (kind <= 1 || kind == 7) begin
        set_in(0, 0, 0, 0, 0);
      end else if (kind <= 5) begin
        bit dir, tgt;
        dir = 1'($urandom_range(0, 1));
        tgt = 1'($urandom_range(0, 1));
        set_in(dir, !dir, tgt, !tgt, 0);
      end else begin
        set_in(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
               1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 0);
      end
      if ($urandom_range(0, 24) == 0) begin
        pre = 1'b1;
        len = $urandom_range(1, 4);
      end
      for (int j = 0; j < len; j++) tick();
      i += len;
    end
    set_in(0, 0, 0, 0, 0);
    wait_idle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
